// File: rtl/pipe4_core.sv
// pipe4_core: parametrised in-order IF/ID/EX/WB integer core with host-loaded memories.
// Build option FORWARD_EN: EX-stage forwarding; when undefined, RAW hazards use interlock stalls.
module pipe4_core #(
  parameter  int DATA_W     = 8,
  parameter  int NREGS      = 8,
  parameter  int IMEM_DEPTH = 8,
  parameter  int DMEM_DEPTH = 16,
  parameter  int INSTR_W    = 16,
  localparam int RA_W       = $clog2(NREGS),
  localparam int PC_W       = $clog2(IMEM_DEPTH),
  localparam int DA_W       = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  input  logic              dmem_we,
  input  logic [DA_W-1:0]   dmem_waddr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [RA_W-1:0]   dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              retire_valid,
  output logic [RA_W-1:0]   retire_rd,
  output logic [DATA_W-1:0] retire_data,
  output logic [15:0]       stall_cnt
);

  localparam int FW = 2 + 3 * RA_W;
  localparam logic [FW-1:0] NOP_IW = {2'b11, {(FW-2){1'b0}}};

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_NOP  = 2'b11
  } op_t;

  // Only the decoded field bits of each instruction word are stored.
  logic [FW-1:0]     imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] rf   [NREGS];

  logic [FW-1:0]     if_id;
  op_t               id_op;
  logic [RA_W-1:0]   id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_a, id_b;

  op_t               ex_op;
  logic [RA_W-1:0]   ex_rd;
  logic [DATA_W-1:0] ex_a, ex_b, op_a, op_b, ex_res;

  logic              wb_wf;
  logic [RA_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              stall;

  if (INSTR_W > FW) begin : g_pad
    logic unused_low_bits;
    assign unused_low_bits = ^imem_wdata[INSTR_W-FW-1:0];
  end

  always_comb begin
    id_op = op_t'(if_id[FW-1 -: 2]);
    id_rs = if_id[FW-3 -: RA_W];
    id_rt = if_id[FW-3-RA_W -: RA_W];
    id_rd = if_id[RA_W-1:0];
    // Write-through: a register written this edge is read with its new value.
    id_a  = (wb_wf && wb_rd == id_rs) ? wb_data : rf[id_rs];
    id_b  = (wb_wf && wb_rd == id_rt) ? wb_data : rf[id_rt];
  end

`ifdef FORWARD_EN
  logic [RA_W-1:0] ex_rs, ex_rt;
  assign op_a  = (wb_wf && wb_rd == ex_rs) ? wb_data : ex_a;
  assign op_b  = (wb_wf && wb_rd == ex_rt) ? wb_data : ex_b;
  assign stall = 1'b0;
`else
  logic reads_rs, reads_rt;
  assign op_a     = ex_a;
  assign op_b     = ex_b;
  assign reads_rs = (id_op != OP_NOP);
  assign reads_rt = (id_op == OP_ADD) || (id_op == OP_SUB);
  assign stall    = (ex_op != OP_NOP) &&
                    ((reads_rs && id_rs == ex_rd) || (reads_rt && id_rt == ex_rd));
`endif

  always_comb begin
    ex_res = '0;
    case (ex_op)
      OP_ADD:  ex_res = op_a + op_b;
      OP_SUB:  ex_res = op_a - op_b;
      OP_LOAD: ex_res = dmem[op_a[DA_W-1:0]];
      OP_NOP:  ex_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata[INSTR_W-1 -: FW];
    if (dmem_we) dmem[dmem_waddr] <= dmem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= '0;
      if_id     <= NOP_IW;
      ex_op     <= OP_NOP;
      ex_rd     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
`ifdef FORWARD_EN
      ex_rs     <= '0;
      ex_rt     <= '0;
`endif
      wb_wf     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      stall_cnt <= '0;
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (en) begin
      if (stall) begin
        // pc and IF_ID hold; a bubble enters EX.
        ex_op <= OP_NOP;
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
      end else begin
        pc    <= pc + 1'b1;
        if_id <= imem[pc];
        ex_op <= id_op;
        ex_rd <= id_rd;
        ex_a  <= id_a;
        ex_b  <= id_b;
`ifdef FORWARD_EN
        ex_rs <= id_rs;
        ex_rt <= id_rt;
`endif
      end
      wb_wf   <= (ex_op != OP_NOP);
      wb_rd   <= ex_rd;
      wb_data <= ex_res;
      if (wb_wf) rf[wb_rd] <= wb_data;
    end
  end

  assign dbg_rdata    = rf[dbg_raddr];
  assign retire_valid = wb_wf;
  assign retire_rd    = wb_rd;
  assign retire_data  = wb_data;

endmodule

// File: tb/tb_pipe4_core.sv
// Bench for pipe4_core: an architectural (in-order ISA) model plus a retire-timing model
// checked every cycle, with hand-computed register/stall expectations per program.
module tb_pipe4_core;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int NS = 32;

  logic        clk = 1'b0, reset_n = 1'b0, en = 1'b0;
  logic        imem_we = 1'b0, dmem_we = 1'b0;
  logic [2:0]  imem_waddr = '0, dbg_raddr = '0;
  logic [15:0] imem_wdata = '0;
  logic [3:0]  dmem_waddr = '0;
  logic [7:0]  dmem_wdata = '0;
  logic [7:0]  dbg_rdata, retire_data;
  logic [2:0]  pc, retire_rd;
  logic        retire_valid;
  logic [15:0] stall_cnt;

  pipe4_core #(.DATA_W(8), .NREGS(8), .IMEM_DEPTH(8), .DMEM_DEPTH(16), .INSTR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc(pc),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_data(retire_data),
    .stall_cnt(stall_cnt)
  );

  always #10 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int act;
  bit chk = 1'b0;

  logic [15:0] prog [8];
  logic [7:0]  dm   [16];
  int          T    [NS];
  int          ST   [NS];
  bit          W    [NS];
  logic [2:0]  RD   [NS];
  logic [7:0]  DATA [NS];
  logic [7:0]  REGS [NS][8];

  always @(posedge clk or negedge reset_n)
    if (!reset_n) act <= 0;
    else if (en)  act <= act + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic [1:0] op, input logic [2:0] rs,
                                      input logic [2:0] rt, input logic [2:0] rd);
    return {op, rs, rt, rd, 5'b00000};
  endfunction

  // Runs the looping program in order; instruction k reaches EX_WB after k+3 enabled
  // edges plus every interlock bubble up to and including its own.
  task automatic build();
    logic [7:0]  r [8];
    logic [7:0]  val;
    logic [15:0] iw;
    logic [1:0]  op;
    logic [2:0]  rs, rt, rdd, prd;
    int          s;
    bit          pw, haz;
    for (int i = 0; i < 8; i++) r[i] = 8'h00;
    s = 0; pw = 1'b0; prd = 3'd0;
    for (int k = 0; k < NS; k++) begin
      iw = prog[k % 8];
      op = iw[15:14]; rs = iw[13:11]; rt = iw[10:8]; rdd = iw[7:5];
      haz = !FWD && pw && ((op != 2'b11 && rs == prd) || (op[1] == 1'b0 && rt == prd));
      if (haz) s++;
      T[k]  = k + 3 + s;
      ST[k] = haz ? T[k] - 2 : -1;
      case (op)
        2'b00:   val = r[rs] + r[rt];
        2'b01:   val = r[rs] - r[rt];
        2'b10:   val = dm[r[rs][3:0]];
        default: val = 8'h00;
      endcase
      W[k] = (op != 2'b11); RD[k] = rdd; DATA[k] = val;
      if (W[k]) r[rdd] = val;
      for (int i = 0; i < 8; i++) REGS[k][i] = r[i];
      pw = W[k]; prd = rdd;
    end
  endtask

  function automatic int nstall(input int a);
    int n = 0;
    for (int k = 0; k < NS; k++) if (ST[k] >= 0 && ST[k] <= a) n++;
    return n;
  endfunction

  function automatic logic [7:0] exp_reg(input int a, input int r);
    logic [7:0] v = 8'h00;
    for (int k = 0; k < NS; k++) if (T[k] + 1 <= a) v = REGS[k][r];
    return v;
  endfunction

  always @(negedge clk) begin : cmp
    int ek;
    bit ev;
    if (chk) begin
      ev = 1'b0; ek = 0;
      for (int k = 0; k < NS; k++) if (T[k] == act) begin ev = W[k]; ek = k; end
      check("pc", {29'd0, pc}, (act - nstall(act)) % 8);
      check("stall_cnt", {16'd0, stall_cnt}, nstall(act));
      check("retire_valid", {31'd0, retire_valid}, {31'd0, ev});
      if (ev) begin
        check("retire_rd", {29'd0, retire_rd}, {29'd0, RD[ek]});
        check("retire_data", {24'd0, retire_data}, {24'd0, DATA[ek]});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic start();
    chk = 1'b0; reset_n = 1'b0; en = 1'b1;
    build();
    for (int i = 0; i < 16; i++) begin
      imem_we = (i < 8); imem_waddr = i[2:0]; imem_wdata = prog[i % 8];
      dmem_we = 1'b1;    dmem_waddr = i[3:0]; dmem_wdata = dm[i];
      step(1);
    end
    imem_we = 1'b0; dmem_we = 1'b0;
    reset_n = 1'b1; chk = 1'b1;
  endtask

  task automatic check_regs(input string tag);
    en = 1'b0;
    for (int r = 0; r < 8; r++) begin
      dbg_raddr = r[2:0]; #1;
      check({tag, "_reg"}, {24'd0, dbg_rdata}, {24'd0, exp_reg(act, r)});
    end
    en = 1'b1;
  endtask

  task automatic rd_reg(input string nm, input int r, input logic [7:0] e);
    dbg_raddr = r[2:0]; #1;
    check(nm, {24'd0, dbg_rdata}, {24'd0, e});
  endtask

  task automatic prog_t3();
    for (int i = 0; i < 16; i++) dm[i] = 8'h00;
    dm[0] = 8'h01; dm[1] = 8'h02;
    for (int i = 0; i < 8; i++) prog[i] = 16'hC000;
    prog[0] = enc(2'b10, 3'd0, 3'd0, 3'd1);
    prog[1] = enc(2'b10, 3'd1, 3'd0, 3'd2);
    prog[2] = enc(2'b01, 3'd1, 3'd2, 3'd4);
    prog[3] = enc(2'b00, 3'd4, 3'd1, 3'd5);
  endtask

  task automatic prog_t4();
    for (int i = 0; i < 16; i++) dm[i] = 8'h00;
    dm[0] = 8'h07;
    for (int i = 0; i < 8; i++) prog[i] = 16'hC000;
    prog[0] = enc(2'b10, 3'd0, 3'd0, 3'd1);
    prog[2] = enc(2'b00, 3'd1, 3'd1, 3'd3);
    prog[4] = enc(2'b00, 3'd3, 3'd3, 3'd4);
  endtask

  initial begin
    // all-NOP program
    for (int i = 0; i < 8; i++)  prog[i] = 16'hC000;
    for (int i = 0; i < 16; i++) dm[i] = 8'h00;
    start();
    check("reset_retire_rd", {29'd0, retire_rd}, 0);
    check("reset_retire_data", {24'd0, retire_data}, 0);
    step(4);
    check("t1_pc", {29'd0, pc}, 4);
    check("t1_stall", {16'd0, stall_cnt}, 0);
    check_regs("t1");

    // LOAD chain then dependent ADD
    for (int i = 0; i < 8; i++) prog[i] = 16'hC000;
    prog[0] = enc(2'b10, 3'd0, 3'd0, 3'd1);
    prog[2] = enc(2'b10, 3'd1, 3'd0, 3'd2);
    prog[3] = enc(2'b00, 3'd2, 3'd2, 3'd3);
    dm[0] = 8'h03; dm[3] = 8'h05;
    start();
    check("t2_model_gap", T[3] - T[2], FWD ? 1 : 2);
    step(3);
    check("t2_first_valid", {31'd0, retire_valid}, 1);
    check("t2_first_rd", {29'd0, retire_rd}, 1);
    check("t2_first_data", {24'd0, retire_data}, 8'h03);
    step(7);
    check_regs("t2");
    rd_reg("t2_r3", 3, 8'h0A);
    check("t2_stall", {16'd0, stall_cnt}, FWD ? 0 : 1);

    // SUB wrap and ADD back to zero
    prog_t3();
    start();
    step(11);
    check_regs("t3");
    rd_reg("t3_r4", 4, 8'hFF);
    rd_reg("t3_r5", 5, 8'h00);
    check("t3_stall", {16'd0, stall_cnt}, FWD ? 0 : 3);

    // dependency two slots later: write-through only
    prog_t4();
    start();
    step(9);
    check_regs("t4");
    rd_reg("t4_r3", 3, 8'h0E);
    rd_reg("t4_r4", 4, 8'h1C);
    check("t4_stall", {16'd0, stall_cnt}, 0);

    // freeze for 5 cycles mid-program
    prog_t3();
    start();
    step(5);
    en = 1'b0;
    step(5);
    en = 1'b1;
    step(6);
    check_regs("t5");
    rd_reg("t5_r4", 4, 8'hFF);
    rd_reg("t5_r5", 5, 8'h00);
    check("t5_stall", {16'd0, stall_cnt}, FWD ? 0 : 3);

    // asynchronous reset while a write-back is pending
    prog_t4();
    start();
    step(5);
    check("t6_valid", {31'd0, retire_valid}, 1);
    check("t6_rd", {29'd0, retire_rd}, 3);
    check("t6_data", {24'd0, retire_data}, 8'h0E);
    #3;
    chk = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t6_pc_async", {29'd0, pc}, 0);
    check("t6_valid_async", {31'd0, retire_valid}, 0);
    step(1);
    rd_reg("t6_r3", 3, 8'h00);
    rd_reg("t6_r1", 1, 8'h00);
    reset_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
